// File: rtl/lut_or_main.sv
// lut_or_main: per-lane LUT2 cells with a configurable truth table (default INIT=4'hE -> y = a | b).
// Define LUT_OR_OUTPUT_REG_EN to register y (1-cycle latency, async active-high reset to 0).

module lut_or_main_lut2 #(
    parameter logic [3:0] INIT = 4'hE
) (
    input  logic i0,
    input  logic i1,
    output logic o
);
    // Nested conditionals: an X/Z select yields the candidate bit when both agree, else X.
    assign o = i1 ? (i0 ? INIT[3] : INIT[2]) : (i0 ? INIT[1] : INIT[0]);
endmodule

module lut_or_main #(
    parameter int         WIDTH = 1,
    parameter logic [3:0] INIT  = 4'hE
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);
    logic [WIDTH-1:0] w_lut;

    if (WIDTH < 1) begin : g_width_check
        $error("lut_or_main: WIDTH must be >= 1");
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        lut_or_main_lut2 #(.INIT(INIT)) u_lut (
            .i0 (a[i]),
            .i1 (b[i]),
            .o  (w_lut[i])
        );
    end

`ifdef LUT_OR_OUTPUT_REG_EN
    logic [WIDTH-1:0] r_y;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_y <= '0;
        end else begin
            r_y <= w_lut;
        end
    end

    assign y = r_y;
`else
    logic w_unused_clk_rst;

    assign w_unused_clk_rst = clock ^ reset;
    assign y = w_lut;
`endif
endmodule

// File: tb/tb_lut_or_main.sv
// Self-checking bench for lut_or_main: vector table, reset sequences and random stimulus vs. a truth-table model.
// Works in both builds (with or without LUT_OR_OUTPUT_REG_EN).

module tb_lut_or_main;
    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] a8    = '0;
    logic [7:0] b8    = '0;
    logic [0:0] y1;
    logic [7:0] y_or8;
    logic [7:0] y_and8;
    logic [3:0] y_xor4;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    lut_or_main #(.WIDTH(1)) dut_or1 (
        .clock(clock), .reset(reset), .a(a8[0:0]), .b(b8[0:0]), .y(y1)
    );
    lut_or_main #(.WIDTH(8)) dut_or8 (
        .clock(clock), .reset(reset), .a(a8), .b(b8), .y(y_or8)
    );
    lut_or_main #(.WIDTH(8), .INIT(4'h8)) dut_and8 (
        .clock(clock), .reset(reset), .a(a8), .b(b8), .y(y_and8)
    );
    lut_or_main #(.WIDTH(4), .INIT(4'h6)) dut_xor4 (
        .clock(clock), .reset(reset), .a(a8[3:0]), .b(b8[3:0]), .y(y_xor4)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] y_or;
        logic [7:0] y_and;
    } vec_t;

    vec_t vecs[7];

    // Truth-table lookup straight from the LUT definition: y[i] = init[2*b[i] + a[i]].
    function automatic logic [7:0] ref_lut(logic [3:0] init, logic [7:0] a, logic [7:0] b, int w);
        logic [7:0] r;
        r = '0;
        for (int i = 0; i < w; i++) begin
            int idx;
            idx  = 2 * int'(b[i]) + int'(a[i]);
            r[i] = init[idx];
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h expected=%h", name, act, exp);
        end
    endtask

    // Let the result reach y: combinational settle, or one posedge when registered.
    task automatic settle();
`ifdef LUT_OR_OUTPUT_REG_EN
        @(posedge clock);
        #1;
`else
        #1;
`endif
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_or1"},  {7'b0, y1},     {7'b0, a8[0] | b8[0]});
        chk({tag, "_or8"},  y_or8,          a8 | b8);
        chk({tag, "_and8"}, y_and8,         ref_lut(4'h8, a8, b8, 8));
        chk({tag, "_xor4"}, {4'b0, y_xor4}, ref_lut(4'h6, a8, b8, 4));
    endtask

    initial begin
        vecs[0] = '{a: 8'hA5, b: 8'h0F, y_or: 8'hAF, y_and: 8'h05};
        vecs[1] = '{a: 8'h0F, b: 8'hA5, y_or: 8'hAF, y_and: 8'h05};
        vecs[2] = '{a: 8'h00, b: 8'h00, y_or: 8'h00, y_and: 8'h00};
        vecs[3] = '{a: 8'hFF, b: 8'h00, y_or: 8'hFF, y_and: 8'h00};
        vecs[4] = '{a: 8'h00, b: 8'hFF, y_or: 8'hFF, y_and: 8'h00};
        vecs[5] = '{a: 8'hFF, b: 8'hFF, y_or: 8'hFF, y_and: 8'hFF};
        vecs[6] = '{a: 8'h3C, b: 8'hC3, y_or: 8'hFF, y_and: 8'h00};

        // Reset phase: a=1, b=0 held, reset asserted before any clock edge.
        a8 = 8'h01;
        b8 = 8'h00;
        #1;
`ifdef LUT_OR_OUTPUT_REG_EN
        chk("rst_async_or1", {7'b0, y1}, 8'h00);
        chk("rst_async_or8", y_or8, 8'h00);
`else
        chk("rst_comb_or1", {7'b0, y1}, 8'h01);
        a8 = 8'h00;
        b8 = 8'h01;
        #1;
        chk("rst_comb_b_only", {7'b0, y1}, 8'h01);
        chk("rst_comb_and8", y_and8, 8'h00);
        a8 = 8'h01;
        b8 = 8'h00;
`endif
        repeat (3) @(posedge clock);
        #1;
`ifdef LUT_OR_OUTPUT_REG_EN
        chk("rst_held_or1", {7'b0, y1}, 8'h00);
`else
        chk("rst_held_or1", {7'b0, y1}, 8'h01);
`endif
        @(negedge clock);
        reset = 1'b0;
        #1;
`ifdef LUT_OR_OUTPUT_REG_EN
        chk("rel_before_edge", {7'b0, y1}, 8'h00);
`endif
        for (int c = 0; c < 3; c++) begin
            @(posedge clock);
            #1;
            chk("run_after_rst", {7'b0, y1}, 8'h01);
        end

        // AND table indexing: a=1,b=1 -> 1; a=1,b=0 -> 0.
        a8 = 8'h01; b8 = 8'h01;
        settle();
        chk("and_11", y_and8, 8'h01);
        a8 = 8'h01; b8 = 8'h00;
        settle();
        chk("and_10", y_and8, 8'h00);

        for (int i = 0; i < 7; i++) begin
            a8 = vecs[i].a;
            b8 = vecs[i].b;
            settle();
            chk($sformatf("vec%0d_or8", i),  y_or8,  vecs[i].y_or);
            chk($sformatf("vec%0d_and8", i), y_and8, vecs[i].y_and);
            chk($sformatf("vec%0d_or1", i),  {7'b0, y1}, {7'b0, vecs[i].y_or[0]});
        end

        for (int n = 0; n < 200; n++) begin
            a8 = 8'($urandom);
            b8 = 8'($urandom);
            settle();
            check_all("rand");
        end

        // Mid-run reset reassertion.
        a8 = 8'hA5; b8 = 8'h0F;
        settle();
        @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
`ifdef LUT_OR_OUTPUT_REG_EN
        chk("midrun_rst_or8", y_or8, 8'h00);
        chk("midrun_rst_xor4", {4'b0, y_xor4}, 8'h00);
`else
        chk("midrun_rst_or8", y_or8, 8'hAF);
        chk("midrun_rst_xor4", {4'b0, y_xor4}, 8'h0A);
`endif
        @(negedge clock);
        reset = 1'b0;
        settle();
        chk("post_midrun_or8", y_or8, 8'hAF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
